// File: rtl/timebase_ctrl_if.sv
// Output bundle of the stopwatch timebase controller.
//   tick  : one-cycle pulse at the tick rate while running
//   clr   : one-cycle pulse that zeroes the downstream BCD digits
//   run   : high while the FSM is in RUNNING
//   state : FSM encoding, STOPPED=00 RUNNING=01 PAUSED=10
// master drives the bundle (timebase_ctrl); slave consumes it (BCD counter).
interface timebase_ctrl_if;
    logic       tick;
    logic       clr;
    logic       run;
    logic [1:0] state;

    modport master (output tick, clr, run, state);
    modport slave  (input  tick, clr, run, state);
endinterface

// File: rtl/timebase_ctrl.sv
// Stopwatch timebase: debounces start/stop and clear pushbuttons, runs a
// STOPPED/RUNNING/PAUSED FSM and divides CLOCK_50 down to a tick pulse.
//   CLOCK_50 : sole clock, rising edge
//   KEY[0]   : asynchronous active-low reset
//   KEY[1]   : start/stop pushbutton (active-low)
//   KEY[2]   : clear pushbutton (active-low)
//   KEY[3]   : unused
//   bus      : registered outputs tick/clr/run/state (timebase_ctrl_if.master)
module timebase_ctrl #(
    parameter int CLK_HZ          = 50000000,
    parameter int TICK_HZ         = 1,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic             CLOCK_50,
    input  logic [3:0]       KEY,
    timebase_ctrl_if.master  bus
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [PW-1:0]  PRE_LAST = PW'(DIV - 1);
    localparam logic [DBW-1:0] CNT_LAST = DBW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ST_STOPPED = 2'b00;
    localparam logic [1:0] ST_RUNNING = 2'b01;
    localparam logic [1:0] ST_PAUSED  = 2'b10;

    logic w_rst_n;
    logic w_unused_key3;
    assign w_rst_n       = KEY[0];
    assign w_unused_key3 = KEY[3];

    // Key path, bit 0 = start/stop (KEY[1]), bit 1 = clear (KEY[2]).
    logic [1:0]          r_sync1, r_sync2;
    logic [1:0]          r_deb, r_deb_d;
    logic [1:0]          r_armed;
    logic [1:0]          r_press;
    logic [1:0][DBW-1:0] r_cnt;
    // Fills with ones over the first two cycles after reset so the
    // synchronizer holds a genuine KEY sample before arming is decided.
    logic [1:0]          r_flush;

    always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
            r_deb   <= '1;
            r_deb_d <= '1;
            r_armed <= '0;
            r_press <= '0;
            r_cnt   <= '0;
            r_flush <= '0;
        end else begin
            r_flush <= {r_flush[0], 1'b1};
            r_sync1 <= KEY[2:1];
            r_sync2 <= r_sync1;
            r_deb_d <= r_deb;
            // A key is armed only once it has been seen released after
            // reset, so a button held through reset release is ignored
            // until it is let go and pressed again.
            r_press <= r_armed & r_deb_d & ~r_deb;
            for (int k = 0; k < 2; k++) begin
                if (r_sync2[k] == r_deb[k]) begin
                    r_cnt[k] <= '0;
                end else if (r_cnt[k] == CNT_LAST) begin
                    r_cnt[k] <= '0;
                    r_deb[k] <= r_sync2[k];
                end else begin
                    r_cnt[k] <= r_cnt[k] + 1'b1;
                end
                if (r_flush[1] && r_deb[k] && r_sync2[k])
                    r_armed[k] <= 1'b1;
            end
        end
    end

    logic w_ss_evt, w_clr_evt;
    assign w_ss_evt  = r_press[0];
    assign w_clr_evt = r_press[1];

    logic [1:0]    r_state;
    logic [PW-1:0] r_pre;
    logic          r_tick, r_clr, r_run;

    // Priority: clear, then start/stop, then prescaler counting. A state
    // change on the wrap cycle therefore suppresses that tick and the
    // prescaler keeps DIV-1, wrapping on the first cycle after resume.
    always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= ST_STOPPED;
            r_pre   <= '0;
            r_tick  <= 1'b0;
            r_clr   <= 1'b0;
            r_run   <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            r_clr  <= 1'b0;
            if (w_clr_evt) begin
                r_state <= ST_STOPPED;
                r_pre   <= '0;
                r_clr   <= 1'b1;
                r_run   <= 1'b0;
            end else if (w_ss_evt) begin
                case (r_state)
                    ST_STOPPED: begin r_state <= ST_RUNNING; r_run <= 1'b1; end
                    ST_RUNNING: begin r_state <= ST_PAUSED;  r_run <= 1'b0; end
                    ST_PAUSED:  begin r_state <= ST_RUNNING; r_run <= 1'b1; end
                    default:    begin r_state <= ST_STOPPED; r_run <= 1'b0; end
                endcase
            end else if (r_state == ST_RUNNING) begin
                if (r_pre == PRE_LAST) begin
                    r_pre  <= '0;
                    r_tick <= 1'b1;
                end else begin
                    r_pre <= r_pre + 1'b1;
                end
            end else if (r_state == ST_STOPPED) begin
                r_pre <= '0;
            end
        end
    end

    assign bus.tick  = r_tick;
    assign bus.clr   = r_clr;
    assign bus.run   = r_run;
    assign bus.state = r_state;
endmodule

// File: doc/timebase_ctrl.md
TIMEBASE_CTRL -- requirements
Module: timebase_ctrl

Interface
REQ-001 Parameter CLK_HZ, 50000000, input clock frequency in Hz.
REQ-002 Parameter TICK_HZ, 1, output tick rate in Hz; DIV = CLK_HZ/TICK_HZ, integer, >= 2.
REQ-003 Parameter DEBOUNCE_CYCLES, 1000000, consecutive stable cycles for a key change to be accepted (20 ms at 50 MHz).
REQ-004 CLOCK_50  input  1  sole clock; all state updates on its rising edge.
REQ-005 KEY  input  4  pushbuttons, active-low; KEY[0] is the reset, asynchronous and active-low; KEY[1] start/stop; KEY[2] clear; KEY[3] unused.
REQ-006 tick  output  1  one-cycle pulse at TICK_HZ while running; enables the downstream BCD counter increment.
REQ-007 clr  output  1  one-cycle pulse that synchronously zeroes the downstream BCD digits.
REQ-008 run  output  1  high while in RUNNING.
REQ-009 state  output  2  FSM encoding: STOPPED=00, RUNNING=01, PAUSED=10; 11 is never driven.

Function
REQ-010 KEY[1] and KEY[2] SHALL each pass through a 2-flop synchronizer; both flops reset to 1 (released).
REQ-011 Per key, a debounced level reg (reset 1) SHALL change only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles; any cycle of agreement SHALL clear that key's debounce counter.
REQ-012 A press event SHALL be a one-cycle internal pulse on a debounced 1->0 transition; releases SHALL generate no event.
REQ-013 Key-to-effect latency SHALL be exactly DEBOUNCE_CYCLES+3 rising edges, counted from the first edge that samples the key low, to the edge where state/clr update.
REQ-014 FSM transitions on start/stop press: STOPPED->RUNNING, RUNNING->PAUSED, PAUSED->RUNNING.
REQ-015 Clear press from any state SHALL go to STOPPED, assert clr for exactly one cycle, and zero the prescaler.
REQ-016 Clear and start/stop press in the same cycle: clear SHALL win; the start/stop event is discarded.
REQ-017 The prescaler SHALL be $clog2(DIV) bits wide and count 0..DIV-1 only in RUNNING; it SHALL wrap from DIV-1 to 0, pulsing tick for one cycle on that wrap.
REQ-018 In PAUSED the prescaler SHALL hold its value, preserving phase on resume; in STOPPED it SHALL be held at 0.
REQ-019 The first tick after STOPPED->RUNNING SHALL occur exactly DIV cycles after the transition edge; the spacing between consecutive ticks in RUNNING SHALL be exactly DIV cycles.
REQ-020 If a pause takes effect in the cycle where the prescaler equals DIV-1, the state change SHALL take priority: no tick is issued and the prescaler holds DIV-1; the first cycle after resume SHALL produce the wrap and the tick.
REQ-021 tick SHALL never be high in STOPPED or PAUSED, and SHALL never be high in the same cycle as clr.
REQ-022 All outputs SHALL be registered with no combinational path from KEY to any output.

Reset
REQ-023 KEY[0]=0 SHALL immediately (without a clock) force state=STOPPED, run=0, tick=0, clr=0, prescaler=0, debounce counters=0, and debounced/synchronizer regs=1.
REQ-024 Reset asserted mid-count or mid-debounce SHALL discard all partial progress; key presses held across reset release SHALL not generate events until released and pressed again.

Verification (CLK_HZ=20, TICK_HZ=1, DEBOUNCE_CYCLES=4, so DIV=20)
REQ-025 Pulse KEY[0] low, then high; hold KEY[1] and KEY[2] high for 100 cycles -> state=00, tick, clr and run stay 0 throughout.
REQ-026 Press KEY[1] for 10 cycles -> state=01 exactly 7 edges after first low sample; ticks follow at +20, +40 and +60 cycles, each 1 cycle wide.
REQ-027 While RUNNING, press KEY[1] with the prescaler at 7 -> PAUSED, prescaler holds 7, no tick; press again -> RUNNING, next tick 13 cycles after resume.
REQ-028 Glitch KEY[1] low for 3 cycles, then high -> no state change, debounce counter returns to 0.
REQ-029 Press KEY[1] and KEY[2] simultaneously while RUNNING -> state=00, single clr pulse, no further ticks.
REQ-030 Assert KEY[0] while RUNNING with prescaler at 15 -> all outputs 0 asynchronously; after release, no tick for 200 cycles.
